// File: rtl/qed_pkg.sv
// Shared types and defaults for the SQED commit/check tracker.
package qed_pkg;

   // Default width of the retired-instruction counters.
   localparam int QED_CNT_W = 8;

   // Commit-tracker FSM state; the encoding is visible on the sif_state port.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      HALT   = 2'd2
   } sif_state_t;

endpackage

// File: rtl/qed_sat_counter.sv
// Saturating up-counter with synchronous clear and an at-max flag.
// An increment requested at the maximum value is dropped; the owner uses
// at_max to detect that case.
module qed_sat_counter
   import qed_pkg::*;
#(
   parameter int CNT_W = QED_CNT_W
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             at_max
);

   localparam logic [CNT_W-1:0] MAX_VAL = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] ONE_VAL = CNT_W'(1);

   logic [CNT_W-1:0] cnt_r;
   logic             at_max_s;

   // Flag the all-ones value so the counter sticks there.
   always_comb begin
      at_max_s = (cnt_r == MAX_VAL);
   end

   // Clear has priority; otherwise count up when enabled and not saturated.
   always_ff @(posedge clk) begin
      if (clr) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (en && !at_max_s) begin
         cnt_r <= cnt_r + ONE_VAL;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cnt    = cnt_r;
   assign at_max = at_max_s;

endmodule

// File: rtl/qed_commit_tracker.sv
// Producer side of the SQED commit/check handshake: picks the single commit
// point T_C, counts original and duplicate retirements afterwards, and flags
// when the core is quiescent with matching counts.
module qed_commit_tracker
   import qed_pkg::*;
#(
   parameter int CNT_W = QED_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             commit_req,
   input  logic             pipe_empty,
   input  logic             mem_busy,
   input  logic             retire_valid,
   input  logic             retire_dup,
   output logic [1:0]       sif_state,
   output logic             sif_commit,
   output logic             sif_commit_pulsed,
   output logic [CNT_W-1:0] qed_num_orig,
   output logic [CNT_W-1:0] qed_num_dup,
   output logic             qed_check_valid,
   output logic             order_err
);

   localparam logic [CNT_W-1:0] ONE_VAL = CNT_W'(1);

   sif_state_t       state_r;
   logic             commit_r;
   logic             pulse_r;
   logic             order_err_r;

   logic             active_s;
   logic             commit_go_s;
   logic             inc_orig_s;
   logic             inc_dup_s;
   logic             sat_hit_s;
   logic             orig_at_max_s;
   logic             dup_at_max_s;
   logic [CNT_W-1:0] orig_cnt_s;
   logic [CNT_W-1:0] dup_cnt_s;
   logic [CNT_W-1:0] orig_next_s;
   logic [CNT_W-1:0] dup_next_s;

   // Qualify retirements (ACTIVE only), detect saturation and the commit condition.
   always_comb begin
      active_s    = (state_r == ACTIVE);
      commit_go_s = commit_req && pipe_empty && !mem_busy;
      inc_orig_s  = active_s && retire_valid && !retire_dup;
      inc_dup_s   = active_s && retire_valid && retire_dup;
      sat_hit_s   = (inc_orig_s && orig_at_max_s) || (inc_dup_s && dup_at_max_s);
      if (inc_orig_s && !orig_at_max_s) begin
         orig_next_s = orig_cnt_s + ONE_VAL;
      end else begin
         orig_next_s = orig_cnt_s;
      end
      if (inc_dup_s && !dup_at_max_s) begin
         dup_next_s = dup_cnt_s + ONE_VAL;
      end else begin
         dup_next_s = dup_cnt_s;
      end
   end

   qed_sat_counter #(.CNT_W(CNT_W)) u_orig_cnt (
      .clk    (clk),
      .clr    (rst),
      .en     (inc_orig_s),
      .cnt    (orig_cnt_s),
      .at_max (orig_at_max_s)
   );

   qed_sat_counter #(.CNT_W(CNT_W)) u_dup_cnt (
      .clk    (clk),
      .clr    (rst),
      .en     (inc_dup_s),
      .cnt    (dup_cnt_s),
      .at_max (dup_at_max_s)
   );

   // Commit FSM: one T_C per run, commit level and pulse registered together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         commit_r <= 1'b0;
         pulse_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (commit_go_s) begin
                  state_r  <= ACTIVE;
                  commit_r <= 1'b1;
                  pulse_r  <= 1'b1;
               end else begin
                  state_r  <= IDLE;
                  commit_r <= 1'b0;
                  pulse_r  <= 1'b0;
               end
            end
            ACTIVE: begin
               commit_r <= 1'b1;
               pulse_r  <= 1'b0;
               if (sat_hit_s) begin
                  state_r <= HALT;
               end else begin
                  state_r <= ACTIVE;
               end
            end
            HALT: begin
               state_r  <= HALT;
               commit_r <= 1'b1;
               pulse_r  <= 1'b0;
            end
            default: begin
               state_r  <= IDLE;
               commit_r <= 1'b0;
               pulse_r  <= 1'b0;
            end
         endcase
      end
   end

   // Sticky ordering error: duplicates ran ahead of originals after the update.
   always_ff @(posedge clk) begin
      if (rst) begin
         order_err_r <= 1'b0;
      end else if (active_s && (dup_next_s > orig_next_s)) begin
         order_err_r <= 1'b1;
      end else begin
         order_err_r <= order_err_r;
      end
   end

   // Consistency may be checked only with equal non-zero counts and an idle core.
   always_comb begin
      qed_check_valid = commit_r && (state_r == ACTIVE) &&
                        (orig_cnt_s == dup_cnt_s) &&
                        (orig_cnt_s != {CNT_W{1'b0}}) &&
                        pipe_empty && !mem_busy && !retire_valid;
   end

   assign sif_state         = state_r;
   assign sif_commit        = commit_r;
   assign sif_commit_pulsed = pulse_r;
   assign qed_num_orig      = orig_cnt_s;
   assign qed_num_dup       = dup_cnt_s;
   assign order_err         = order_err_r;

endmodule

// File: tb/tb_qed_commit_tracker.sv
// Randomised and directed bench for qed_commit_tracker against a behavioural
// model of the commit/count rules (4-bit counters so saturation is reachable).
module tb_qed_commit_tracker;

   localparam int CNT_W = 4;
   localparam int MAXV  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             commit_req = 1'b0;
   logic             pipe_empty = 1'b0;
   logic             mem_busy = 1'b0;
   logic             retire_valid = 1'b0;
   logic             retire_dup = 1'b0;
   logic [1:0]       sif_state;
   logic             sif_commit;
   logic             sif_commit_pulsed;
   logic [CNT_W-1:0] qed_num_orig;
   logic [CNT_W-1:0] qed_num_dup;
   logic             qed_check_valid;
   logic             order_err;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model: phase 0 waiting for T_C, 1 counting, 2 halted.
   int m_phase, m_orig, m_dup, m_pulses;
   bit m_commit, m_pulse, m_err;

   qed_commit_tracker #(.CNT_W(CNT_W)) dut (
      .clk               (clk),
      .rst               (rst),
      .commit_req        (commit_req),
      .pipe_empty        (pipe_empty),
      .mem_busy          (mem_busy),
      .retire_valid      (retire_valid),
      .retire_dup        (retire_dup),
      .sif_state         (sif_state),
      .sif_commit        (sif_commit),
      .sif_commit_pulsed (sif_commit_pulsed),
      .qed_num_orig      (qed_num_orig),
      .qed_num_dup       (qed_num_dup),
      .qed_check_valid   (qed_check_valid),
      .order_err         (order_err)
   );

   // 10 ns core clock.
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Apply one posedge worth of the rules to the model using the current inputs.
   task automatic model_step();
      if (rst) begin
         m_phase = 0; m_commit = 0; m_pulse = 0; m_err = 0;
         m_orig = 0; m_dup = 0; m_pulses = 0;
      end else begin
         m_pulse = 0;
         if (m_phase == 0) begin
            if (commit_req && pipe_empty && !mem_busy) begin
               m_phase = 1; m_commit = 1; m_pulse = 1; m_pulses++;
            end
         end else if (m_phase == 1) begin
            if (retire_valid) begin
               if (retire_dup) begin
                  if (m_dup == MAXV) m_phase = 2; else m_dup++;
               end else begin
                  if (m_orig == MAXV) m_phase = 2; else m_orig++;
               end
            end
            if (m_dup > m_orig) m_err = 1;
         end
      end
   endtask

   task automatic compare_all();
      bit exp_cv;
      exp_cv = m_commit && (m_phase == 1) && (m_orig == m_dup) && (m_orig != 0) &&
               pipe_empty && !mem_busy && !retire_valid;
      chk("state",      32'(sif_state),         32'(m_phase));
      chk("commit",     32'(sif_commit),        32'(m_commit));
      chk("pulse",      32'(sif_commit_pulsed), 32'(m_pulse));
      chk("num_orig",   32'(qed_num_orig),      32'(m_orig));
      chk("num_dup",    32'(qed_num_dup),       32'(m_dup));
      chk("check_valid",32'(qed_check_valid),   32'(exp_cv));
      chk("order_err",  32'(order_err),         32'(m_err));
   endtask

   // Drive one cycle of inputs, check outputs before the edge, then advance the model.
   task automatic cyc(input bit r, input bit q, input bit pe, input bit mb,
                      input bit rv, input bit rd);
      @(negedge clk);
      rst = r; commit_req = q; pipe_empty = pe; mem_busy = mb;
      retire_valid = rv; retire_dup = rd;
      #1;
      compare_all();
      @(posedge clk);
      model_step();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; commit_req = 1'b0; retire_valid = 1'b0;
      @(posedge clk);
      model_step();
   endtask

   task automatic do_commit();
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      do_reset();
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);           // rst beats commit_req
      // Commit blocked while the pipe is busy, then taken.
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      do_commit();
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);           // retire during pulse counts
      // Three originals (one already), three duplicates, quiescent, then mem busy.
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("cv_3_3", 32'(qed_check_valid), 32'd1);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("cv_membusy", 32'(qed_check_valid), 32'd0);
      chk("single_pulse", 32'(m_pulses), 32'd1);
      // Duplicate before any original.
      do_reset();
      do_commit();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("order_err_dup_first", 32'(order_err), 32'd1);
      // Saturation: 16 originals then 15 duplicates.
      do_reset();
      do_commit();
      for (int i = 0; i < MAXV + 1; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < MAXV; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("halt_orig", 32'(qed_num_orig), 32'(MAXV));
      chk("halt_state", 32'(sif_state), 32'd2);
      // Reset mid-run with counts 2/1, then a fresh commit.
      do_reset();
      do_commit();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);           // second request ignored
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      do_commit();
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      // Random traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 63) == 0),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 1) == 1),
             ($urandom_range(0, 1) == 1));
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
